// File: rtl/rgb_led_pkg.sv
// Shared constants for the RGB blink controller: FSM state encodings, display modes, colours.
package rgb_led_pkg;

  localparam logic [1:0] StDisplay  = 2'd0;
  localparam logic [1:0] StFlashOn  = 2'd1;
  localparam logic [1:0] StFlashOff = 2'd2;

  localparam logic [1:0] MODE_HISTORY = 2'd0;
  localparam logic [1:0] MODE_BLINK   = 2'd1;
  localparam logic [1:0] MODE_OFF     = 2'd2;
  localparam logic [1:0] MODE_SOLID   = 2'd3;

  localparam int unsigned COLOR_OFF = 0;

endpackage

// File: rtl/rgb_blink_ctrl_if.sv
// Game-logic side bundle for rgb_blink_ctrl. dim_level exists only when RGB_PWM_EN is defined.
interface rgb_blink_ctrl_if #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned PWM_W    = 4
);
  logic [1:0]                  mode;
  logic [NUM_LEDS-1:0]         blink_mask;
  logic [NUM_LEDS*COLOR_W-1:0] guess_rgb;
  logic [NUM_LEDS*COLOR_W-1:0] history_rgb;
  logic [COLOR_W-1:0]          flash_rgb;
  logic                        flash_start;
  logic                        flash_busy;
  logic                        flash_done;
  logic                        blink_phase;
  logic [NUM_LEDS*COLOR_W-1:0] rgb_out;

`ifdef RGB_PWM_EN
  logic [PWM_W-1:0]            dim_level;

  modport master (
    output mode, blink_mask, guess_rgb, history_rgb, flash_rgb, flash_start, dim_level,
    input  flash_busy, flash_done, blink_phase, rgb_out
  );

  modport slave (
    input  mode, blink_mask, guess_rgb, history_rgb, flash_rgb, flash_start, dim_level,
    output flash_busy, flash_done, blink_phase, rgb_out
  );
`else
  logic unused_pwm_w;
  assign unused_pwm_w = ^PWM_W;

  modport master (
    output mode, blink_mask, guess_rgb, history_rgb, flash_rgb, flash_start,
    input  flash_busy, flash_done, blink_phase, rgb_out
  );

  modport slave (
    input  mode, blink_mask, guess_rgb, history_rgb, flash_rgb, flash_start,
    output flash_busy, flash_done, blink_phase, rgb_out
  );
`endif

endinterface

// File: rtl/blink_timebase.sv
// Blink half-period counter: cnt runs 0..HALF_PERIOD-1, phase toggles on wrap.
// clear_i restarts the half-period with cnt=0 and phase on.
module blink_timebase #(
  parameter int unsigned HALF_PERIOD = 8
) (
  input  logic blink_clk,
  input  logic rst,
  input  logic clear_i,
  output logic wrap_o,
  output logic phase_o
);

  localparam int unsigned CntW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  assign wrap_o  = (cnt_q == CntW'(HALF_PERIOD - 1));
  assign phase_o = phase_q;

  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    phase_d = phase_q;
    if (clear_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (wrap_o) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge blink_clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/rgb_blink_ctrl.sv
// N-LED RGB output stage: history / guess / flash source select with registered outputs.
// Optional brightness gating is compiled in with RGB_PWM_EN.
module rgb_blink_ctrl
  import rgb_led_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 4,
  parameter int unsigned COLOR_W     = 3,
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned FLASH_COUNT = 3,
  parameter int unsigned PWM_W       = 4
) (
  input  logic            blink_clk,
  input  logic            rst,
  rgb_blink_ctrl_if.slave bus
);

  localparam int unsigned RgbW = NUM_LEDS * COLOR_W;
  localparam int unsigned FcW  = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT + 1) : 1;

  logic [1:0]      state_q, state_d;
  logic [FcW-1:0]  fc_q, fc_d;
  logic            flash_busy_q, flash_busy_d;
  logic            flash_done_q, flash_done_d;
  logic [RgbW-1:0] rgb_q, rgb_d;
  logic [RgbW-1:0] led_drive;
  logic            tb_wrap, tb_phase, tb_clear;

  blink_timebase #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timebase (
    .blink_clk (blink_clk),
    .rst       (rst),
    .clear_i   (tb_clear),
    .wrap_o    (tb_wrap),
    .phase_o   (tb_phase)
  );

  always_comb begin
    state_d      = state_q;
    fc_d         = fc_q;
    flash_done_d = 1'b0;
    case (state_q)
      StDisplay: begin
        // The cycle flash_done is high still reads as DISPLAY; refuse starts there.
        if (bus.flash_start && !flash_done_q) begin
          state_d = StFlashOn;
          fc_d    = FcW'(FLASH_COUNT);
        end
      end
      StFlashOn: begin
        if (tb_wrap) state_d = StFlashOff;
      end
      StFlashOff: begin
        if (tb_wrap) begin
          fc_d = fc_q - FcW'(1);
          if (fc_q == FcW'(1)) begin
            state_d      = StDisplay;
            flash_done_d = 1'b1;
          end else begin
            state_d = StFlashOn;
          end
        end
      end
      default: state_d = StDisplay;
    endcase
  end

  assign tb_clear     = (state_d == StFlashOn) && (state_q != StFlashOn);
  assign flash_busy_d = (state_d != StDisplay);

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    logic [COLOR_W-1:0] led;

    always_comb begin
      led = COLOR_W'(COLOR_OFF);
      case (state_q)
        StFlashOn:  led = bus.flash_rgb;
        StFlashOff: led = COLOR_W'(COLOR_OFF);
        default: begin
          unique case (bus.mode)
            MODE_HISTORY: led = bus.history_rgb[i*COLOR_W +: COLOR_W];
            MODE_BLINK: begin
              if (tb_phase || !bus.blink_mask[i]) led = bus.guess_rgb[i*COLOR_W +: COLOR_W];
            end
            MODE_OFF:     led = COLOR_W'(COLOR_OFF);
            MODE_SOLID:   led = bus.guess_rgb[i*COLOR_W +: COLOR_W];
          endcase
        end
      endcase
    end

    assign led_drive[i*COLOR_W +: COLOR_W] = led;
  end

`ifdef RGB_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             pwm_pass;

  assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
  // Full-scale dim_level must be steady on, not on for all but one count.
  assign pwm_pass  = (pwm_cnt_q < bus.dim_level) || (&bus.dim_level);
  assign rgb_d     = pwm_pass ? led_drive : '0;

  always_ff @(posedge blink_clk) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end
`else
  logic unused_pwm_w;
  assign unused_pwm_w = ^PWM_W;
  assign rgb_d        = led_drive;
`endif

  always_ff @(posedge blink_clk) begin
    if (rst) begin
      state_q      <= StDisplay;
      fc_q         <= '0;
      flash_busy_q <= 1'b0;
      flash_done_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      fc_q         <= fc_d;
      flash_busy_q <= flash_busy_d;
      flash_done_q <= flash_done_d;
      rgb_q        <= rgb_d;
    end
  end

  assign bus.flash_busy  = flash_busy_q;
  assign bus.flash_done  = flash_done_q;
  assign bus.blink_phase = tb_phase;
  assign bus.rgb_out     = rgb_q;

endmodule

// File: tb/tb_rgb_blink_ctrl.sv
// Directed bench for rgb_blink_ctrl with a queue-based scoreboard of per-cycle expectations.
module tb_rgb_blink_ctrl;

  localparam int unsigned NL = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned HP = 4;
  localparam int unsigned FC = 2;
  localparam int unsigned PW = 4;

  typedef struct packed {
    logic [NL*CW-1:0] rgb;
    logic             busy;
    logic             done;
    logic             phase;
    logic             chk_phase;
  } exp_t;

  logic   blink_clk;
  logic   rst;
  exp_t   sb_q[$];
  string  tag_q[$];
  int     checks;
  int     errors;

  rgb_blink_ctrl_if #(.NUM_LEDS(NL), .COLOR_W(CW), .PWM_W(PW)) bus ();

  rgb_blink_ctrl #(
    .NUM_LEDS    (NL),
    .COLOR_W     (CW),
    .HALF_PERIOD (HP),
    .FLASH_COUNT (FC),
    .PWM_W       (PW)
  ) dut (
    .blink_clk (blink_clk),
    .rst       (rst),
    .bus       (bus)
  );

  initial blink_clk = 1'b0;
  always #5 blink_clk = ~blink_clk;

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic step(input string tag, input logic [NL*CW-1:0] rgb, input logic busy,
                      input logic done, input logic phase, input logic chk_phase);
    exp_t e;
    string t;
    sb_q.push_back('{rgb: rgb, busy: busy, done: done, phase: phase, chk_phase: chk_phase});
    tag_q.push_back(tag);
    @(posedge blink_clk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (bus.rgb_out === e.rgb) else begin
      errors++;
      $error("FAIL %s rgb_out: observed %h expected %h", t, bus.rgb_out, e.rgb);
    end
    checks++;
    assert (bus.flash_busy === e.busy) else begin
      errors++;
      $error("FAIL %s flash_busy: observed %b expected %b", t, bus.flash_busy, e.busy);
    end
    checks++;
    assert (bus.flash_done === e.done) else begin
      errors++;
      $error("FAIL %s flash_done: observed %b expected %b", t, bus.flash_done, e.done);
    end
    if (e.chk_phase) begin
      checks++;
      assert (bus.blink_phase === e.phase) else begin
        errors++;
        $error("FAIL %s blink_phase: observed %b expected %b", t, bus.blink_phase, e.phase);
      end
    end
  endtask

`ifdef RGB_PWM_EN
  task automatic pwm_window(input string tag, input logic [PW-1:0] dim, input int exp_on);
    int on_cnt;
    int off_cnt;
    on_cnt  = 0;
    off_cnt = 0;
    bus.dim_level = dim;
    @(posedge blink_clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      @(posedge blink_clk);
      #1;
      if (bus.rgb_out === 12'hFFF) on_cnt++;
      else if (bus.rgb_out === 12'h000) off_cnt++;
    end
    checks++;
    assert (on_cnt == exp_on && off_cnt == 16 - exp_on) else begin
      errors++;
      $error("FAIL %s on_cycles: observed %0d on %0d off expected %0d on %0d off",
             tag, on_cnt, off_cnt, exp_on, 16 - exp_on);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst              = 1'b1;
    bus.mode         = 2'd0;
    bus.blink_mask   = '0;
    bus.guess_rgb    = '0;
    bus.history_rgb  = 12'hABC;
    bus.flash_rgb    = '0;
    bus.flash_start  = 1'b0;
`ifdef RGB_PWM_EN
    bus.dim_level    = '1;
`endif

    // Reset and history display
    repeat (3) step("reset", 12'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    repeat (3) step("history", 12'hABC, 1'b0, 1'b0, 1'b1, 1'b1);

    // Guess + blink, LEDs 0 and 2 masked
    bus.mode       = 2'd1;
    bus.guess_rgb  = 12'hFFF;
    bus.blink_mask = 4'b0101;
    step("blink_first", 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step("blink_off", 12'hE38, 1'b0, 1'b0, 1'b0, 1'b1);
    step("blink_off", 12'hE38, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step("blink_on", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    step("blink_on", 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flash sequence with flash_start held high throughout
    bus.flash_start = 1'b1;
    bus.flash_rgb   = 3'b010;
    step("flash_req", 12'hE38, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) step("flash_on1", 12'h492, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step("flash_off1", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step("flash_on2", 12'h492, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step("flash_off2", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    step("flash_done", 12'h000, 1'b0, 1'b1, 1'b1, 1'b1);
    step("start_on_done", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    step("restart", 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b1);
    bus.flash_start = 1'b0;

    // Reset on the sixth cycle of the new sequence
    repeat (4) step("abort_on", 12'h492, 1'b1, 1'b0, 1'b0, 1'b0);
    step("abort_off", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step("abort_rst", 12'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    repeat (3) step("resume_on", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    step("resume_on", 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    step("resume_off", 12'hE38, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef RGB_PWM_EN
    bus.mode = 2'd3;
    pwm_window("pwm_dim4", 4'd4, 4);
    pwm_window("pwm_dim0", 4'd0, 0);
    pwm_window("pwm_dim15", 4'd15, 16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
